// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the load/store initiator and for any other block that
// needs to decode RV32I load/store funct3 values or the data memory write
// enable encoding (e.g. the core's writeback path).
//
// Contents:
//   WE_*        data memory write-enable encodings
//   F3_*        RV32I load/store funct3 codes
//   state_t     load/store initiator FSM states
//   funct3_legal, access_size, store_we   small decode helpers
package lsu_pkg;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_BYTE = 2'b11;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Stores only exist in signed-looking flavours; the unsigned codes are
    // load-only.
    function automatic logic funct3_legal(input logic store, input logic [2:0] funct3);
        logic ok;
        ok = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        if (!store) begin
            ok = ok || (funct3 == F3_BU) || (funct3 == F3_HU);
        end
        return ok;
    endfunction

    // Number of bytes touched by the access. Illegal codes fall to 4; they are
    // rejected by funct3_legal before the size matters.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        logic [2:0] size;
        case (funct3)
            F3_B, F3_BU: size = 3'd1;
            F3_H, F3_HU: size = 3'd2;
            default:     size = 3'd4;
        endcase
        return size;
    endfunction

    function automatic logic [1:0] store_we(input logic [2:0] funct3);
        logic [1:0] we;
        case (funct3)
            F3_B:    we = WE_BYTE;
            F3_H:    we = WE_HALF;
            default: we = WE_WORD;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// lsu_mem_master_if
// Request/response handshake bundle between the execute stage and the
// load/store initiator.
//
// Signals:
//   req_valid/req_ready   request handshake
//   req_store             1 = store, 0 = load
//   req_funct3            RV32I funct3
//   req_addr              byte address
//   req_wdata             store data, LSB-aligned
//   rsp_valid/rsp_ready   response handshake
//   rsp_rdata             extended load data (0 for stores and errors)
//   rsp_err               request rejected
//
// Modports:
//   master  requester side (execute stage / testbench)
//   slave   load/store initiator side
interface lsu_mem_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BYTE_SIZE  = 4
);

    logic                     req_valid;
    logic                     req_ready;
    logic                     req_store;
    logic [2:0]               req_funct3;
    logic [ADDR_WIDTH-1:0]    req_addr;
    logic [BYTE_SIZE*8-1:0]   req_wdata;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [BYTE_SIZE*8-1:0]   rsp_rdata;
    logic                     rsp_err;

    modport master (
        output req_valid,
        output req_store,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_rdata,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  req_store,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_rdata,
        output rsp_err
    );

endinterface

// File: rtl/lsu_mem_master_load_extend.sv
// load_extend
// Combinational load data extension for RV32I loads. Kept standalone so the
// writeback path can reuse it on raw memory data.
//
// Ports:
//   rd      raw memory read data (LSB-aligned)
//   funct3  load funct3 (LB/LH/LW/LBU/LHU)
//   data    sign/zero-extended result; codes other than byte/half pass rd
module load_extend
    import lsu_pkg::*;
#(
    parameter int BYTE_SIZE = 4
) (
    input  logic [BYTE_SIZE*8-1:0] rd,
    input  logic [2:0]             funct3,
    output logic [BYTE_SIZE*8-1:0] data
);

    localparam int DW = BYTE_SIZE * 8;

    always_comb begin
        data = rd;
        case (funct3)
            F3_B:    data = {{(DW-8){rd[7]}}, rd[7:0]};
            F3_BU:   data = {{(DW-8){1'b0}}, rd[7:0]};
            F3_H:    data = {{(DW-16){rd[15]}}, rd[15:0]};
            F3_HU:   data = {{(DW-16){1'b0}}, rd[15:0]};
            default: data = rd;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master
// Load/store initiator for the byte-addressed data memory. Takes one RV32I
// load or store at a time, performs the memory access in its own cycle and
// returns a held response (extended load data, or an error flag for an
// illegal funct3 / out-of-range access).
//
// Ports:
//   clk, rst_n   clock and synchronous active-low reset
//   bus          request/response handshake (slave side)
//   WE           memory write enable: 00 none, 01 word, 10 half, 11 byte
//   ADDR         memory byte address (last accepted request address)
//   WD           memory write data (last accepted store data)
//   RD           memory read data, combinational from ADDR
//
// FSM:
//   IDLE   | ready for a request; checks it on acceptance
//   ACCESS | one memory cycle: store commits or load data is captured
//   RESP   | response held until the consumer takes it
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int BYTE_SIZE  = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    lsu_mem_master_if.slave        bus,
    output logic [1:0]             WE,
    output logic [ADDR_WIDTH-1:0]  ADDR,
    output logic [BYTE_SIZE*8-1:0] WD,
    input  logic [BYTE_SIZE*8-1:0] RD
);

    localparam int DW  = BYTE_SIZE * 8;
    localparam int AW1 = ADDR_WIDTH + 1;

    state_t                 state;
    logic                   lat_store;
    logic [2:0]             lat_funct3;
    logic [ADDR_WIDTH-1:0]  lat_addr;
    logic [DW-1:0]          lat_wdata;
    logic [1:0]             we_q;
    logic                   ready_q;
    logic                   rsp_valid_q;
    logic                   rsp_err_q;
    logic [DW-1:0]          rsp_rdata_q;

    logic [DW-1:0]          load_data;
    logic [AW1-1:0]         last_byte;
    logic                   req_bad;

    // One extra address bit so an access near the top of the address space
    // cannot wrap around and look in-range.
    always_comb begin
        last_byte = {1'b0, bus.req_addr} + AW1'(access_size(bus.req_funct3)) - AW1'(1);
        req_bad   = !funct3_legal(bus.req_store, bus.req_funct3)
                    || (last_byte >= AW1'(MEM_DEPTH));
    end

    load_extend #(
        .BYTE_SIZE (BYTE_SIZE)
    ) u_load_extend (
        .rd     (RD),
        .funct3 (lat_funct3),
        .data   (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            we_q        <= WE_NONE;
            lat_store   <= 1'b0;
            lat_funct3  <= '0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        lat_store   <= bus.req_store;
                        lat_funct3  <= bus.req_funct3;
                        lat_addr    <= bus.req_addr;
                        lat_wdata   <= bus.req_wdata;
                        ready_q     <= 1'b0;
                        rsp_rdata_q <= '0;
                        if (req_bad) begin
                            // Rejected requests skip the memory entirely.
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= RESP;
                        end else begin
                            rsp_err_q <= 1'b0;
                            we_q      <= bus.req_store ? store_we(bus.req_funct3) : WE_NONE;
                            state     <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    // Store commits at this edge; load data is sampled here.
                    we_q        <= WE_NONE;
                    rsp_rdata_q <= lat_store ? '0 : load_data;
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    we_q        <= WE_NONE;
                    rsp_valid_q <= 1'b0;
                    ready_q     <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // Gating WE with rst_n directly means a reset landing mid-ACCESS kills the
    // write at that same edge rather than one cycle later.
    assign WE   = rst_n ? we_q : WE_NONE;
    assign ADDR = lat_addr;
    assign WD   = lat_wdata;

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lsu_mem_master_if #(.ADDR_WIDTH(32), .BYTE_SIZE(4)) bus ();

    logic [1:0]  WE;
    logic [31:0] ADDR;
    logic [31:0] WD;
    logic [31:0] RD;

    lsu_mem_master #(
        .BYTE_SIZE  (4),
        .ADDR_WIDTH (32),
        .MEM_DEPTH  (256)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .WE    (WE),
        .ADDR  (ADDR),
        .WD    (WD),
        .RD    (RD)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int we_cnt = 0;
    logic [1:0] we_last = 2'b00;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;
    exp_t sb[$];

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37) ^ 8'hA5);
    endfunction

    // Memory driven by the DUT's port
    logic [7:0] mem [256];
    logic       mem_init_done = 1'b0;
    logic [7:0] rd_a;

    always @(posedge clk) begin
        edge_cnt++;
        if (!mem_init_done) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_byte(i);
            mem_init_done <= 1'b1;
        end else begin
            case (WE)
                2'b11: mem[ADDR[7:0]] <= WD[7:0];
                2'b10: begin
                    mem[ADDR[7:0]]              <= WD[7:0];
                    mem[8'(ADDR[7:0] + 8'd1)]   <= WD[15:8];
                end
                2'b01: begin
                    mem[ADDR[7:0]]              <= WD[7:0];
                    mem[8'(ADDR[7:0] + 8'd1)]   <= WD[15:8];
                    mem[8'(ADDR[7:0] + 8'd2)]   <= WD[23:16];
                    mem[8'(ADDR[7:0] + 8'd3)]   <= WD[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_a = ADDR[7:0];
        RD   = {mem[8'(rd_a + 8'd3)], mem[8'(rd_a + 8'd2)], mem[8'(rd_a + 8'd1)], mem[rd_a]};
    end

    always @(negedge clk) begin
        if (WE != 2'b00) begin
            we_cnt++;
            we_last = WE;
        end
    end

    // Reference model, independent of the DUT memory
    logic [7:0] ref_mem [256];

    task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd);
        exp_t e;
        logic legal;
        int size;
        logic [63:0] last;
        logic [7:0] b;
        logic [31:0] w;
        legal = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        last  = {32'd0, a} + 64'(size) - 64'd1;
        b     = a[7:0];
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.lat   = 1;
        if (!legal || last >= 64'd256) begin
            e.err = 1'b1;
            e.lat = 0;
        end else if (st) begin
            for (int k = 0; k < size; k++) ref_mem[8'(b + 8'(k))] = wd[8*k +: 8];
        end else begin
            w = {ref_mem[8'(b + 8'd3)], ref_mem[8'(b + 8'd2)], ref_mem[8'(b + 8'd1)], ref_mem[b]};
            case (f3)
                3'd0:    e.rdata = {{24{w[7]}}, w[7:0]};
                3'd4:    e.rdata = {24'd0, w[7:0]};
                3'd1:    e.rdata = {{16{w[15]}}, w[15:0]};
                3'd5:    e.rdata = {16'd0, w[15:0]};
                default: e.rdata = w;
            endcase
        end
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output int acc_edge);
        int n = 0;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc_edge = edge_cnt + 1;
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout: req_ready=%b required 1", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic receive(input int acc_edge, input int hold, input string tag);
        int n = 0;
        exp_t e;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.rsp_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL %s_rsp_timeout: rsp_valid=%b queued=%0d required valid with expectation",
                     tag, bus.rsp_valid, sb.size());
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s_rdata: got %h required %h", tag, bus.rsp_rdata, e.rdata);
        end
        checks++;
        if (bus.rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s_err: got %b required %b", tag, bus.rsp_err, e.err);
        end
        checks++;
        if (edge_cnt - acc_edge != e.lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d required %0d", tag, edge_cnt - acc_edge, e.lat);
        end
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                checks++;
                if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err) begin
                    errors++;
                    $display("FAIL %s_hold_stable: valid=%b rdata=%h err=%b required 1 %h %b",
                             tag, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, e.rdata, e.err);
                end
                checks++;
                if (bus.req_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s_hold_ready: req_ready=%b required 0", tag, bus.req_ready);
                end
            end
            bus.rsp_ready = 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_rsp_release: rsp_valid=%b required 0", tag, bus.rsp_valid);
        end
    endtask

    task automatic op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input string tag);
        int acc;
        send(st, f3, a, wd, acc);
        model(st, f3, a, wd);
        receive(acc, 0, tag);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b err=%b rdata=%h required 0 0 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        checks++;
        if (WE !== 2'b00 || ADDR !== 32'd0 || WD !== 32'd0) begin
            errors++;
            $display("FAIL reset_mem_port: WE=%b ADDR=%h WD=%h required 00 0 0", WE, ADDR, WD);
        end
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b required 1", bus.req_ready);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_word();
        int w0 = we_cnt;
        op(1'b1, F3_W, 32'h10, 32'hDEADBEEF, "sw");
        checks++;
        if (we_cnt - w0 != 1 || we_last !== WE_WORD) begin
            errors++;
            $display("FAIL sw_we: cycles=%0d last=%b required 1 cycle of 01", we_cnt - w0, we_last);
        end
        op(1'b0, F3_W, 32'h10, 32'h0, "lw");
    endtask

    task automatic test_byte();
        op(1'b1, F3_B, 32'h21, 32'h000000F0, "sb");
        op(1'b0, F3_B, 32'h21, 32'h0, "lb");
        op(1'b0, F3_BU, 32'h21, 32'h0, "lbu");
        checks++;
        if (mem[8'h20] !== ref_mem[8'h20] || mem[8'h22] !== ref_mem[8'h22] || mem[8'h21] !== 8'hF0) begin
            errors++;
            $display("FAIL sb_neighbours: mem20=%h mem21=%h mem22=%h required %h f0 %h",
                     mem[8'h20], mem[8'h21], mem[8'h22], ref_mem[8'h20], ref_mem[8'h22]);
        end
    endtask

    task automatic test_half();
        op(1'b1, F3_H, 32'h31, 32'h00008001, "sh");
        op(1'b0, F3_H, 32'h31, 32'h0, "lh");
        op(1'b0, F3_HU, 32'h31, 32'h0, "lhu");
    endtask

    task automatic test_errors();
        int w0 = we_cnt;
        op(1'b0, F3_W, 32'hFD, 32'h0, "lw_range");
        op(1'b1, 3'b011, 32'h50, 32'h55, "sb_f3");
        op(1'b1, F3_BU, 32'h50, 32'h55, "store_f3_4");
        op(1'b0, F3_H, 32'hFF, 32'h0, "lh_range");
        op(1'b0, F3_W, 32'hFFFF_FFFF, 32'h0, "lw_wrap");
        checks++;
        if (we_cnt - w0 != 0) begin
            errors++;
            $display("FAIL err_we: write cycles=%0d required 0", we_cnt - w0);
        end
        op(1'b0, F3_W, 32'hFC, 32'h0, "lw_top");
        op(1'b0, F3_B, 32'hFF, 32'h0, "lb_top");
    endtask

    task automatic test_hold();
        int acc;
        bus.rsp_ready = 1'b0;
        send(1'b0, F3_W, 32'h10, 32'h0, acc);
        model(1'b0, F3_W, 32'h10, 32'h0);
        // pending request presented while the response is stalled
        bus.req_store  = 1'b0;
        bus.req_funct3 = F3_HU;
        bus.req_addr   = 32'h12;
        bus.req_wdata  = 32'h0;
        bus.req_valid  = 1'b1;
        receive(acc, 5, "hold_lw");
        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_next_ready: req_ready=%b required 1", bus.req_ready);
        end
        acc = edge_cnt + 1;
        model(1'b0, F3_HU, 32'h12, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        receive(acc, 0, "hold_next");
    endtask

    task automatic test_reset_during_access();
        int acc;
        send(1'b1, F3_W, 32'h40, 32'h12345678, acc);
        checks++;
        if (WE !== WE_WORD) begin
            errors++;
            $display("FAIL rst_access_we_before: WE=%b required 01", WE);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (WE !== 2'b00) begin
            errors++;
            $display("FAIL rst_access_we_gated: WE=%b required 00", WE);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 ||
            ADDR !== 32'd0 || WD !== 32'd0 || WE !== 2'b00) begin
            errors++;
            $display("FAIL rst_access_outputs: valid=%b err=%b rdata=%h ADDR=%h WD=%h WE=%b required all 0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, ADDR, WD, WE);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_access_release: req_ready=%b rsp_valid=%b required 1 0",
                     bus.req_ready, bus.rsp_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mem[8'(8'h40 + 8'(k))] !== ref_mem[8'(8'h40 + 8'(k))]) begin
                errors++;
                $display("FAIL rst_access_mem%0d: got %h required %h", k,
                         mem[8'(8'h40 + 8'(k))], ref_mem[8'(8'h40 + 8'(k))]);
            end
        end
        op(1'b0, F3_W, 32'h40, 32'h0, "rst_access_lw");
    endtask

    task automatic test_back_to_back();
        int acc;
        int prev_acc = 0;
        int prev_lat = 0;
        logic st;
        logic [2:0] f3;
        logic [31:0] a;
        logic [31:0] wd;
        for (int i = 0; i < 40; i++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = 32'($urandom_range(0, 255));
            wd = $urandom();
            send(st, f3, a, wd, acc);
            if (i > 0) begin
                checks++;
                if (acc - prev_acc != prev_lat + 2) begin
                    errors++;
                    $display("FAIL b2b_turnaround%0d: got %0d edges required %0d",
                             i, acc - prev_acc, prev_lat + 2);
                end
            end
            model(st, f3, a, wd);
            prev_lat = sb[sb.size()-1].lat;
            prev_acc = acc;
            receive(acc, 0, "b2b");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.rsp_ready  = 1'b1;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_hold();
        test_reset_during_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
